// File: rtl/gf180mcu_fd_sc_mcu9t5v0__oai211_arc_seq_pkg.sv
// Shared types and constants for the OAI211 arc sweep sequencer.
// Vector code layout: {A1, A2, B, C}, MSB first.
package gf180mcu_fd_sc_mcu9t5v0__oai211_arc_seq_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    DRIVE  = 3'd1,
    WAIT   = 3'd2,
    CHECK  = 3'd3,
    FINISH = 3'd4
  } state_t;

  localparam int NUM_VEC = 16;

  localparam int BIT_A1 = 3;
  localparam int BIT_A2 = 2;
  localparam int BIT_B  = 1;
  localparam int BIT_C  = 0;

endpackage

// File: rtl/gf180mcu_fd_sc_mcu9t5v0__oai211_arc_seq_exp.sv
// Reference OAI211 truth function: ZN = !((A1 | A2) & B & C), decoded from a vector code.
// Purely combinational.
module gf180mcu_fd_sc_mcu9t5v0__oai211_arc_seq_exp
  import gf180mcu_fd_sc_mcu9t5v0__oai211_arc_seq_pkg::*;
(
  input  logic [3:0] code,
  output logic       ZN_EXP
);

  assign ZN_EXP = ~((code[BIT_A1] | code[BIT_A2]) & code[BIT_B] & code[BIT_C]);

endmodule

// File: rtl/gf180mcu_fd_sc_mcu9t5v0__oai211_arc_seq.sv
// Exhaustive 16-vector sweep of an OAI211 cell: drive a code, settle, compare ZN, record errors.
// Each vector costs SETTLE+2 cycles; ABORT returns to IDLE next edge, RN clears everything.
module gf180mcu_fd_sc_mcu9t5v0__oai211_arc_seq
  import gf180mcu_fd_sc_mcu9t5v0__oai211_arc_seq_pkg::*;
#(
  parameter int SETTLE = 2
) (
  input  logic       CLK,
  input  logic       RN,
  input  logic       START,
  input  logic       ABORT,
  input  logic       ZN_OBS,
  output logic       A1,
  output logic       A2,
  output logic       B,
  output logic       C,
  output logic       BUSY,
  output logic       DONE,
  output logic       PASS,
  output logic [4:0] ERR_CNT,
  output logic [3:0] FAIL_CODE,
  output logic       FAIL_VLD
);

  if (SETTLE < 1 || SETTLE > 15) begin : g_bad_settle
    $error("SETTLE must be in 1..15");
  end

  localparam logic [3:0] WAIT_INIT = 4'(SETTLE - 1);
  localparam logic [3:0] LAST_IDX  = 4'(NUM_VEC - 1);

  state_t     state;
  logic [3:0] idx;
  logic [3:0] cnt;
  logic [3:0] stim;
  logic       zn_exp;
  logic       mismatch;
  logic [4:0] err_nxt;

  gf180mcu_fd_sc_mcu9t5v0__oai211_arc_seq_exp u_exp (
    .code   (idx),
    .ZN_EXP (zn_exp)
  );

  assign mismatch = ZN_OBS ^ zn_exp;
  assign err_nxt  = ERR_CNT + {4'd0, mismatch};

  assign A1   = stim[BIT_A1];
  assign A2   = stim[BIT_A2];
  assign B    = stim[BIT_B];
  assign C    = stim[BIT_C];
  assign BUSY = (state != IDLE);

  always_ff @(posedge CLK or negedge RN) begin
    if (!RN) begin
      state     <= IDLE;
      idx       <= 4'd0;
      cnt       <= 4'd0;
      stim      <= 4'd0;
      DONE      <= 1'b0;
      PASS      <= 1'b0;
      ERR_CNT   <= 5'd0;
      FAIL_CODE <= 4'd0;
      FAIL_VLD  <= 1'b0;
    end else begin
      DONE <= 1'b0;
      if (state == IDLE) begin
        // ABORT wins over START; it also drops the held last vector
        if (ABORT) begin
          stim <= 4'd0;
        end else if (START) begin
          idx      <= 4'd0;
          ERR_CNT  <= 5'd0;
          FAIL_VLD <= 1'b0;
          PASS     <= 1'b0;
          state    <= DRIVE;
        end
      end else if (ABORT) begin
        state <= IDLE;
        stim  <= 4'd0;
        PASS  <= 1'b0;
      end else begin
        case (state)
          DRIVE: begin
            stim  <= idx;
            cnt   <= WAIT_INIT;
            state <= WAIT;
          end
          WAIT: begin
            if (cnt == 4'd0) begin
              state <= CHECK;
            end else begin
              cnt <= cnt - 4'd1;
            end
          end
          CHECK: begin
            ERR_CNT <= err_nxt;
            if (mismatch && !FAIL_VLD) begin
              FAIL_CODE <= idx;
              FAIL_VLD  <= 1'b1;
            end
            if (idx == LAST_IDX) begin
              DONE  <= 1'b1;
              PASS  <= (err_nxt == 5'd0);
              state <= FINISH;
            end else begin
              idx   <= idx + 4'd1;
              state <= DRIVE;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_gf180mcu_fd_sc_mcu9t5v0__oai211_arc_seq.sv
// Directed bench: two sequencers (SETTLE=2 and SETTLE=1) sharing clock, reset, START and ABORT.
// ZN_OBS per instance comes from an OAI211 model with selectable fault (good, stuck-1, inverted).
module tb_gf180mcu_fd_sc_mcu9t5v0__oai211_arc_seq;

  logic CLK = 1'b0;
  logic RN = 1'b0;
  logic START = 1'b0;
  logic ABORT = 1'b0;
  int   fault = 0;

  logic a1_0, a2_0, b_0, c_0, busy0, done0, pass0, fv0, zn0;
  logic [4:0] err0;
  logic [3:0] fc0;
  logic a1_1, a2_1, b_1, c_1, busy1, done1, pass1, fv1, zn1;
  logic [4:0] err1;
  logic [3:0] fc1;

  int total = 0;
  int bad = 0;

  always #5 CLK = ~CLK;

  function automatic logic cell_model(input int f, input logic a1, a2, b, c);
    logic e;
    e = ~((a1 | a2) & b & c);
    case (f)
      1:       return 1'b1;
      2:       return ~e;
      default: return e;
    endcase
  endfunction

  assign zn0 = cell_model(fault, a1_0, a2_0, b_0, c_0);
  assign zn1 = cell_model(fault, a1_1, a2_1, b_1, c_1);

  gf180mcu_fd_sc_mcu9t5v0__oai211_arc_seq #(.SETTLE(2)) dut0 (
    .CLK(CLK), .RN(RN), .START(START), .ABORT(ABORT), .ZN_OBS(zn0),
    .A1(a1_0), .A2(a2_0), .B(b_0), .C(c_0),
    .BUSY(busy0), .DONE(done0), .PASS(pass0),
    .ERR_CNT(err0), .FAIL_CODE(fc0), .FAIL_VLD(fv0)
  );

  gf180mcu_fd_sc_mcu9t5v0__oai211_arc_seq #(.SETTLE(1)) dut1 (
    .CLK(CLK), .RN(RN), .START(START), .ABORT(ABORT), .ZN_OBS(zn1),
    .A1(a1_1), .A2(a2_1), .B(b_1), .C(c_1),
    .BUSY(busy1), .DONE(done1), .PASS(pass1),
    .ERR_CNT(err1), .FAIL_CODE(fc1), .FAIL_VLD(fv1)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Edges after the START-sampling edge until DONE0 is seen; -1 on timeout.
  task automatic sweep0(output int lat);
    lat = -1;
    for (int n = 1; n <= 200; n++) begin
      tick();
      if (done0) begin
        lat = n;
        break;
      end
    end
  endtask

  function automatic logic [31:0] all0();
    return {15'd0, busy0, done0, pass0, err0, fc0, fv0, a1_0, a2_0, b_0, c_0};
  endfunction

  function automatic logic [31:0] all1();
    return {15'd0, busy1, done1, pass1, err1, fc1, fv1, a1_1, a2_1, b_1, c_1};
  endfunction

  initial begin
    int lat, lat0, lat1, run, holds, holdbad, dn;
    logic [3:0] prev1;
    logic seen;

    // reset state, before any clock edge
    #3;
    chk("rst_out0", all0(), 32'd0);
    chk("rst_out1", all1(), 32'd0);
    repeat (2) tick();

    // good cell; START on the first edge after release
    RN = 1'b1;
    START = 1'b1;
    tick();
    START = 1'b0;
    chk("first_start_busy", busy0, 1'b1);
    lat0 = -1; lat1 = -1; run = 0; holds = 0; holdbad = 0; seen = 1'b0;
    prev1 = {a1_1, a2_1, b_1, c_1};
    for (int n = 1; n <= 200; n++) begin
      tick();
      if (lat1 < 0) begin
        if ({a1_1, a2_1, b_1, c_1} != prev1) begin
          if (seen) begin
            holds++;
            if (run != 3) holdbad++;
          end
          seen = 1'b1;
          run = 1;
          prev1 = {a1_1, a2_1, b_1, c_1};
        end else begin
          run++;
        end
      end
      if (done1 && lat1 < 0) begin
        lat1 = n;
        chk("good_pass1", pass1, 1'b1);
      end
      if (done0 && lat0 < 0) begin
        lat0 = n;
        chk("good_pass0", pass0, 1'b1);
        chk("good_err0", err0, 5'd0);
        chk("good_fv0", fv0, 1'b0);
      end
      if (lat0 > 0 && lat1 > 0) break;
    end
    chk("lat_settle2", lat0, 64);
    chk("lat_settle1", lat1, 48);
    chk("hold_count_s1", holds, 14);
    chk("hold_bad_s1", holdbad, 0);
    tick();
    chk("done_one_cycle", done0, 1'b0);
    chk("idle_after_finish", busy0, 1'b0);
    chk("hold_code15", {a1_0, a2_0, b_0, c_0}, 4'hf);

    // ZN stuck at 1: codes 7, 11, 15 mismatch
    fault = 1;
    START = 1'b1;
    tick();
    START = 1'b0;
    sweep0(lat);
    chk("stuck_lat", lat, 64);
    chk("stuck_err", err0, 5'd3);
    chk("stuck_fcode", fc0, 4'd7);
    chk("stuck_fvld", fv0, 1'b1);
    chk("stuck_pass", pass0, 1'b0);
    chk("stuck_err_s1", err1, 5'd3);
    tick();

    // inverted cell, ABORT at edge 20
    fault = 2;
    START = 1'b1;
    tick();
    START = 1'b0;
    repeat (19) tick();
    ABORT = 1'b1;
    tick();
    ABORT = 1'b0;
    chk("abort_busy", busy0, 1'b0);
    chk("abort_stim", {a1_0, a2_0, b_0, c_0}, 4'd0);
    chk("abort_err_hold", err0, 5'd4);
    chk("abort_fcode_hold", fc0, 4'd0);
    chk("abort_fvld_hold", fv0, 1'b1);
    chk("abort_pass", pass0, 1'b0);
    chk("abort_busy_s1", busy1, 1'b0);
    chk("abort_err_s1", err1, 5'd6);
    dn = 0;
    repeat (100) begin
      tick();
      if (done0 || done1) dn++;
    end
    chk("abort_no_done", dn, 0);

    // ABORT beats START in IDLE
    START = 1'b1;
    ABORT = 1'b1;
    tick();
    START = 1'b0;
    ABORT = 1'b0;
    chk("abort_prio_idle", busy0, 1'b0);

    // START held for the whole sweep
    fault = 0;
    START = 1'b1;
    tick();
    dn = 0;
    for (int n = 1; n <= 65; n++) begin
      tick();
      if (done0) dn++;
      if (n == 64) chk("held_done_at64", done0, 1'b1);
    end
    chk("held_one_done", dn, 1);
    chk("held_idle_gap", busy0, 1'b0);
    tick();
    chk("held_restart", busy0, 1'b1);
    START = 1'b0;
    ABORT = 1'b1;
    tick();
    ABORT = 1'b0;
    chk("held_abort_clean", busy0, 1'b0);

    // async reset mid-sweep
    START = 1'b1;
    tick();
    START = 1'b0;
    repeat (29) tick();
    chk("pre_rst_busy", busy0, 1'b1);
    #3;
    RN = 1'b0;
    #1;
    chk("async_rst0", all0(), 32'd0);
    chk("async_rst1", all1(), 32'd0);
    #2;
    RN = 1'b1;
    dn = 0;
    repeat (100) begin
      tick();
      if (done0 || done1) dn++;
    end
    chk("rst_no_done", dn, 0);
    START = 1'b1;
    tick();
    START = 1'b0;
    sweep0(lat);
    chk("post_rst_lat", lat, 64);
    chk("post_rst_pass", pass0, 1'b1);
    chk("post_rst_err", err0, 5'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/gf180mcu_fd_sc_mcu9t5v0__oai211_arc_seq.md
GF180MCU_FD_SC_MCU9T5V0__OAI211_ARC_SEQ -- requirements
Module: gf180mcu_fd_sc_mcu9t5v0__oai211_arc_seq

Interface
REQ-001 SHALL have parameter SETTLE, default 2, meaning wait cycles after driving each vector (legal range 1..15).
REQ-002 SHALL have port CLK  input  1  rising-edge clock, the only clock in the block.
REQ-003 SHALL have port RN  input  1  asynchronous active-low reset.
REQ-004 SHALL have port START  input  1  sweep request, sampled only in IDLE.
REQ-005 SHALL have port ABORT  input  1  terminates an active sweep.
REQ-006 SHALL have port ZN_OBS  input  1  observed ZN output of the OAI211 under test.
REQ-007 SHALL have ports A1, A2, B, C  output  1 each  registered stimulus to the OAI211 under test.
REQ-008 SHALL have port BUSY  output  1  high whenever the state is not IDLE.
REQ-009 SHALL have port DONE  output  1  one-cycle completion pulse.
REQ-010 SHALL have port PASS  output  1  sweep result, valid from DONE until the next accepted START.
REQ-011 SHALL have port ERR_CNT  output  5  mismatch count for the current or last sweep.
REQ-012 SHALL have ports FAIL_CODE  output  4  and FAIL_VLD  output  1  first failing vector code and its valid flag.

Function
REQ-013 SHALL encode the vector code as code[3]=A1, code[2]=A2, code[1]=B, code[0]=C.
REQ-014 SHALL define the expected output as ZN_EXP = NOT((A1 OR A2) AND B AND C).
REQ-015 SHALL implement states IDLE, DRIVE, WAIT, CHECK and FINISH.
REQ-016 IDLE: START=1 and ABORT=0 SHALL set idx=0, ERR_CNT=0, FAIL_VLD=0 and PASS=0, then go to DRIVE.
REQ-017 DRIVE: SHALL register {A1,A2,B,C}=idx, load the wait counter with SETTLE-1, then go to WAIT.
REQ-018 WAIT: SHALL decrement the counter each cycle and go to CHECK on the cycle the counter equals 0 (exactly SETTLE cycles in WAIT).
REQ-019 CHECK: SHALL compare ZN_OBS with ZN_EXP(idx).
REQ-020 On a CHECK mismatch, ERR_CNT SHALL increment; if FAIL_VLD=0, FAIL_CODE SHALL be set to idx and FAIL_VLD to 1.
REQ-021 CHECK: SHALL go to FINISH when idx=15; otherwise idx SHALL increment and the state go to DRIVE.
REQ-022 FINISH: DONE SHALL be 1 for exactly one cycle and PASS SHALL be set to (ERR_CNT==0 after the final check); the state then goes to IDLE.
REQ-023 Latency: DONE SHALL go high 16*(SETTLE+2) rising edges after the edge that samples START (64 edges at SETTLE=2).
REQ-024 The stimulus outputs SHALL remain stable through WAIT and CHECK and change only on entry to DRIVE.
REQ-025 START while BUSY=1 SHALL be ignored.
REQ-026 In IDLE, ABORT SHALL have priority over START (no sweep starts).
REQ-027 ABORT in any non-IDLE state SHALL force IDLE at the next edge: A1/A2/B/C=0, PASS=0, no DONE pulse; ERR_CNT, FAIL_CODE and FAIL_VLD hold.
REQ-028 ERR_CNT SHALL be wide enough that it never wraps (maximum value 16).
REQ-029 After FINISH, A1/A2/B/C SHALL hold code 15 until the next START or ABORT.

Reset
REQ-030 RN=0 SHALL immediately force state IDLE, idx=0, counter=0 and all outputs to 0, regardless of CLK.
REQ-031 Reset mid-sweep SHALL discard the sweep, with no DONE pulse after release.
REQ-032 The first START SHALL be accepted on the first rising edge with RN=1.

Structure
REQ-033 Package gf180mcu_fd_sc_mcu9t5v0__oai211_arc_seq_pkg SHALL hold the state enum, NUM_VEC=16 and the code bit-position constants.
REQ-034 The expected-value function SHALL be one sub-module, gf180mcu_fd_sc_mcu9t5v0__oai211_arc_seq_exp (combinational, input 4-bit code, output ZN_EXP).
REQ-035 All sequential logic SHALL reside in the top module.

Verification
REQ-036 SETTLE=2, correct OAI211 model on ZN_OBS, START pulse -> DONE at edge 64, PASS=1, ERR_CNT=0, FAIL_VLD=0.
REQ-037 ZN_OBS stuck at 1 -> ERR_CNT=3 (codes 7, 11, 15), FAIL_CODE=7, FAIL_VLD=1, PASS=0.
REQ-038 ABORT at edge 20 -> next edge BUSY=0 and A1/A2/B/C=0; DONE stays 0 for the following 100 cycles.
REQ-039 START held high for the whole sweep -> exactly one DONE pulse; a new sweep starts on the edge after FINISH.
REQ-040 RN pulsed low at edge 30 -> all outputs 0 asynchronously; a new START after release completes normally.
REQ-041 SETTLE=1 -> DONE at edge 48, and each vector is held for exactly 3 cycles.
